// File: rtl/pulse_train_pkg.sv
// Shared types and sizing helpers for the pulse train generator.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Width of the shared phase down-counter; it must hold the longer phase.
    function automatic int cnt_width(input int high_cycles, input int gap_cycles);
        int longest;
        longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/pulse_train_generator.sv
// Turns single-cycle event strobes into HIGH_CYCLES-long level windows separated
// by GAP_CYCLES low gaps, replaying queued events. PULSE_TRAIN_DONE_EN adds done_out.
module pulse_train_generator
    import pulse_train_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PENDING = 7
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               pulse_in,
    output logic                               level_out,
    output logic                               busy_out,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_out,
`ifdef PULSE_TRAIN_DONE_EN
    output logic                               done_out,
`endif
    output logic                               overflow_out
);

    localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [PW-1:0]   pend_reg, pend_next;
    logic            ovf_reg, ovf_next;
    logic            level_reg, busy_reg;
    logic            phase_last;

    assign phase_last = (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (pulse_in) begin
                    state_next = HIGH;
                    cnt_next   = HIGH_LOAD;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
                if (pulse_in) begin
                    if (pend_reg == PEND_MAX) ovf_next  = 1'b1;
                    else                      pend_next = pend_reg + 1'b1;
                end
            end
            GAP: begin
                if (phase_last) begin
                    // A pulse on the final gap cycle is served immediately, so it
                    // never touches the queue; otherwise one queued event is popped.
                    if (pulse_in || pend_reg != '0) begin
                        state_next = HIGH;
                        cnt_next   = HIGH_LOAD;
                        if (!pulse_in) pend_next = pend_reg - 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                    if (pulse_in) begin
                        if (pend_reg == PEND_MAX) ovf_next  = 1'b1;
                        else                      pend_next = pend_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pend_reg  <= '0;
            ovf_reg   <= 1'b0;
            level_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            ovf_reg   <= ovf_next;
            level_reg <= (state_next == HIGH);
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign level_out    = level_reg;
    assign busy_out     = busy_reg;
    assign pending_out  = pend_reg;
    assign overflow_out = ovf_reg;

`ifdef PULSE_TRAIN_DONE_EN
    logic done_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) done_reg <= 1'b0;
        else        done_reg <= (state_reg == GAP) && phase_last;
    end

    assign done_out = done_reg;
`endif

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed-vector bench for pulse_train_generator (HIGH=4, GAP=2, MAX_PENDING=3).
// Define PULSE_TRAIN_DONE_EN to also check done_out.
module tb_pulse_train_generator;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       pulse_in = 1'b0;
    logic       level_out;
    logic       busy_out;
    logic [1:0] pending_out;
    logic       overflow_out;
`ifdef PULSE_TRAIN_DONE_EN
    logic       done_out;
`endif

    int tests = 0;
    int fails = 0;

    pulse_train_generator #(
        .HIGH_CYCLES(4),
        .GAP_CYCLES (2),
        .MAX_PENDING(3)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .pulse_in    (pulse_in),
        .level_out   (level_out),
        .busy_out    (busy_out),
        .pending_out (pending_out),
`ifdef PULSE_TRAIN_DONE_EN
        .done_out    (done_out),
`endif
        .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    // Outputs are sampled 1 time unit after the active edge; cycle k is the
    // interval following posedge k.
    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // After this returns we sit in cycle 0 with the design freshly reset.
    task automatic do_reset();
        rst_in   = 1'b1;
        pulse_in = 1'b0;
        next_cycle();
        rst_in = 1'b0;
    endtask

    function automatic logic win(input int c, input int s);
        return (c >= s) && (c < s + 4);
    endfunction

    task automatic test_reset();
        logic [4:0] exp_v;
        exp_v    = 5'b0;
        rst_in   = 1'b1;
        pulse_in = 1'b1;
        next_cycle();
        next_cycle();
        tests++;
        if ({level_out, busy_out, pending_out, overflow_out} !== exp_v) begin
            fails++;
            $display("FAIL reset_with_pulse got=%b exp=%b",
                     {level_out, busy_out, pending_out, overflow_out}, exp_v);
        end
        rst_in   = 1'b0;
        pulse_in = 1'b0;
        next_cycle();
        tests++;
        if ({level_out, busy_out, pending_out, overflow_out} !== exp_v) begin
            fails++;
            $display("FAIL reset_idle got=%b exp=%b",
                     {level_out, busy_out, pending_out, overflow_out}, exp_v);
        end
`ifdef PULSE_TRAIN_DONE_EN
        tests++;
        if (done_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_done got=%b exp=0", done_out);
        end
`endif
        $display("[TB] test_reset complete");
    endtask

    task automatic test_single();
        logic [4:0] exp_v;
        logic [4:0] obs;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            exp_v = {win(c, 11), (c >= 11 && c <= 16), 2'd0, 1'b0};
            obs   = {level_out, busy_out, pending_out, overflow_out};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL single cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            pulse_in = (c == 10);
            next_cycle();
        end
        $display("[TB] test_single complete");
    endtask

    task automatic test_two_pulses();
        logic [4:0] exp_v;
        logic [4:0] obs;
        logic [1:0] exp_p;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            exp_p = (c >= 13 && c <= 16) ? 2'd1 : 2'd0;
            exp_v = {win(c, 11) || win(c, 17), (c >= 11 && c <= 22), exp_p, 1'b0};
            obs   = {level_out, busy_out, pending_out, overflow_out};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL two_pulses cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            pulse_in = (c == 10) || (c == 12);
            next_cycle();
        end
        $display("[TB] test_two_pulses complete");
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_v;
        logic [4:0] obs;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            exp_v = {win(c, 11) || win(c, 17), (c >= 11 && c <= 22), 2'd0, 1'b0};
            obs   = {level_out, busy_out, pending_out, overflow_out};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            pulse_in = (c == 10) || (c == 16);
            next_cycle();
        end
        $display("[TB] test_back_to_back complete");
    endtask

    task automatic test_saturation();
        logic [4:0] exp_v;
        logic [4:0] obs;
        logic [1:0] exp_p;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            if      (c <= 11) exp_p = 2'd0;
            else if (c == 12) exp_p = 2'd1;
            else if (c == 13) exp_p = 2'd2;
            else if (c <= 16) exp_p = 2'd3;
            else if (c <= 22) exp_p = 2'd2;
            else if (c <= 28) exp_p = 2'd1;
            else              exp_p = 2'd0;
            exp_v = {win(c, 11) || win(c, 17) || win(c, 23) || win(c, 29),
                     (c >= 11 && c <= 34), exp_p, (c >= 15)};
            obs   = {level_out, busy_out, pending_out, overflow_out};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL saturation cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
`ifdef PULSE_TRAIN_DONE_EN
            tests++;
            if (done_out !== (c == 17 || c == 23 || c == 29 || c == 35)) begin
                fails++;
                $display("FAIL saturation_done cyc=%0d got=%b", c, done_out);
            end
`endif
            pulse_in = (c >= 10 && c <= 15);
            next_cycle();
        end
        $display("[TB] test_saturation complete");
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp_v;
        logic [4:0] obs;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            if (c == 11)      exp_v = {1'b1, 1'b1, 2'd0, 1'b0};
            else if (c == 12) exp_v = {1'b1, 1'b1, 2'd1, 1'b0};
            else              exp_v = 5'b0;
            obs = {level_out, busy_out, pending_out, overflow_out};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            pulse_in = (c == 10) || (c == 11);
            rst_in   = (c == 12);
            next_cycle();
        end
        rst_in = 1'b0;
        $display("[TB] test_reset_mid complete");
    endtask

    task automatic test_held();
        logic [4:0] exp_v;
        logic [4:0] obs;
        logic [1:0] exp_p;
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            if      (c == 12)            exp_p = 2'd1;
            else if (c >= 13 && c <= 16) exp_p = 2'd2;
            else if (c >= 17 && c <= 22) exp_p = 2'd1;
            else                         exp_p = 2'd0;
            exp_v = {win(c, 11) || win(c, 17) || win(c, 23),
                     (c >= 11 && c <= 28), exp_p, 1'b0};
            obs   = {level_out, busy_out, pending_out, overflow_out};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL held cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
`ifdef PULSE_TRAIN_DONE_EN
            tests++;
            if (done_out !== (c == 17 || c == 23 || c == 29)) begin
                fails++;
                $display("FAIL held_done cyc=%0d got=%b", c, done_out);
            end
`endif
            pulse_in = (c >= 10 && c <= 12);
            next_cycle();
        end
        $display("[TB] test_held complete");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_pulses();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_held();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
Converts single-cycle event pulses, such as debounced-button edge pulses, back into timed level windows. Each accepted event produces one high window of HIGH_CYCLES cycles on level_out, followed by a mandatory low gap of GAP_CYCLES cycles. Events arriving while a window or gap is in progress are counted and replayed in order. Used to drive LEDs, buzzers or strobes from pulse-domain control logic.

Parameters:
HIGH_CYCLES, 4, length of each high window in clk_in cycles; must be >= 1
GAP_CYCLES, 2, length of the low gap after each window; must be >= 1
MAX_PENDING, 7, saturation limit of the queued-event counter; must be >= 1

Ports:
clk_in  input  1  system clock, all logic on posedge
rst_in  input  1  synchronous reset, active-high
pulse_in  input  1  event strobe; each cycle sampled high is one event
level_out  output  1  generated waveform, registered
busy_out  output  1  high whenever the state is not IDLE, registered
pending_out  output  $clog2(MAX_PENDING+1)  number of queued events not yet replayed
overflow_out  output  1  sticky flag; set when an event is dropped at saturation

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: state IDLE, level_out 0, busy_out 0, pending_out 0, overflow_out 0, internal counter 0.
- Reset mid-operation: reset takes effect at the next posedge. The window is aborted and pending events are discarded. Reset overrides any simultaneous pulse_in.
- FSM states: IDLE, HIGH, GAP.
- IDLE:
  - pulse_in=1 -> HIGH. level_out=1 and busy_out=1 are visible the next cycle (latency 1).
- HIGH:
  - level_out stays 1 for exactly HIGH_CYCLES cycles, then -> GAP.
- GAP:
  - level_out is 0 for exactly GAP_CYCLES cycles while busy_out stays 1.
  - On the last GAP cycle, if pending_out>0 or pulse_in=1: go directly to HIGH. There is no IDLE cycle between windows.
  - Otherwise go to IDLE.
- pulse_in=1 in HIGH or GAP: counts as a queued event, with these cases:
  - Increment pending, except on the last GAP cycle.
  - On the last GAP cycle with pending=0: the pulse is consumed directly and pending stays 0.
  - On the last GAP cycle with pending>0: the increment and the decrement cancel, so pending is unchanged.
  - On the last GAP cycle with pulse_in=0 and pending>0: pending decrements by 1.
- Saturation: at pending=MAX_PENDING, a further increment is dropped and overflow_out is set. overflow_out is cleared only by rst_in.
- Multi-cycle input: pulse_in held high for N cycles produces N events. The block performs no edge detection.
- Counter: one down-counter of width $clog2(max(HIGH_CYCLES,GAP_CYCLES)+1), reloaded on each state entry.

Optional Feature:
Macro PULSE_TRAIN_DONE_EN.
- Defined: adds output done_out, width 1, reset 0. It pulses high for exactly one cycle in the first cycle after each GAP completes, whether the next state is IDLE or HIGH.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package pulse_train_pkg holds:
  - the state enum typedef (IDLE, HIGH, GAP), 2 bits
  - a localparam function for the counter width
- No sub-module. The FSM, counter and pending counter live in one module.

Test Plan (HIGH_CYCLES=4, GAP_CYCLES=2, MAX_PENDING=3; cycle numbers are posedge indices):
- Single pulse at cycle 10 -> level_out=1 on cycles 11-14, 0 on 15-16 with busy_out=1; busy_out=0 from cycle 17.
- Pulses at cycles 10 and 12 -> windows on 11-14 and 17-20; pending_out=1 on cycles 13-16 and 0 from 17.
- Pulse at 10, second pulse exactly at 16 (last GAP cycle) -> second window on 17-20; pending_out stays 0 throughout.
- Pulse at 10, then 5 pulses on 11-15 -> pending_out saturates at 3, overflow_out=1 from cycle 15 and stays 1; 4 windows total, separated by 2-cycle gaps.
- Pulses at 10 and 11, rst_in=1 at cycle 12 -> cycle 13: level_out=0, busy_out=0, pending_out=0, overflow_out=0; no further windows.
- pulse_in held high on cycles 10-12 -> 3 windows starting at cycles 11, 17 and 23. With PULSE_TRAIN_DONE_EN defined, done_out=1 on cycles 17, 23 and 29 only.
